// File: rtl/fifo_flags_if.sv
// fifo_flags_if: bundles the request strobes, pointer read-back and status outputs of the FIFO
// occupancy/flag controller.
//   master : requester side; drives push/pop/clear_errors and the pointer read-back,
//            observes increments, count, flags and sticky errors.
//   slave  : the fifo_flags controller.
// Parameter A is the FIFO address width; pointers and count are A+1 bits.
interface fifo_flags_if #(
  parameter int unsigned A = 4
);
  logic         push;
  logic         pop;
  logic         clear_errors;
  logic [A:0]   wr_pointer;
  logic [A:0]   rd_pointer;
  logic         wr_increment;
  logic         rd_increment;
  logic [A:0]   count;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic         overflow;
  logic         underflow;
  logic         mismatch;

  modport master (
    output push, pop, clear_errors, wr_pointer, rd_pointer,
    input  wr_increment, rd_increment, count, full, empty, almost_full, almost_empty,
           overflow, underflow, mismatch
  );

  modport slave (
    input  push, pop, clear_errors, wr_pointer, rd_pointer,
    output wr_increment, rd_increment, count, full, empty, almost_full, almost_empty,
           overflow, underflow, mismatch
  );
endinterface

// File: rtl/fifo_flags.sv
// fifo_flags: occupancy and flag controller for a synchronous FIFO of depth 2^A.
// Qualifies push/pop into pointer-counter increments, keeps a registered occupancy count with
// full/empty/almost flags, and latches sticky overflow/underflow errors.
// Optional macro FIFO_FLAGS_CHECK_EN: compares (wr_pointer - rd_pointer) mod 2^(A+1) against
// count every cycle and latches a sticky mismatch; when undefined, mismatch is tied to 0.
// Ports:
//   clk   : clock, rising edge
//   rstn  : asynchronous active-low reset
//   bus   : fifo_flags_if slave (push, pop, clear_errors, wr/rd_pointer in;
//           wr/rd_increment, count, flags, overflow, underflow, mismatch out)
module fifo_flags #(
  parameter int unsigned A        = 4,
  parameter int unsigned AF_LEVEL = 12,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic          clk,
  input  logic          rstn,
  fifo_flags_if.slave   bus
);

  localparam logic [A:0] DepthW = (A+1)'(1 << A);
  localparam logic [A:0] AfW    = (A+1)'(AF_LEVEL);
  localparam logic [A:0] AeW    = (A+1)'(AE_LEVEL);

  logic [A:0] count_q, count_d;
  logic       full_q, empty_q, afull_q, aempty_q;
  logic       overflow_q, overflow_d;
  logic       underflow_q, underflow_d;
  logic       wr_inc, rd_inc;

  // Gated only by registered flags, so the two increments never depend on each other.
  assign wr_inc = bus.push & ~full_q;
  assign rd_inc = bus.pop & ~empty_q;

  always_comb begin
    count_d     = count_q + {{A{1'b0}}, wr_inc} - {{A{1'b0}}, rd_inc};
    // A set condition in the same cycle takes priority over clear_errors.
    overflow_d  = (bus.push & full_q) | (overflow_q & ~bus.clear_errors);
    underflow_d = (bus.pop & empty_q) | (underflow_q & ~bus.clear_errors);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      full_q      <= (count_d == DepthW);
      empty_q     <= (count_d == '0);
      afull_q     <= (count_d >= AfW);
      aempty_q    <= (count_d <= AeW);
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef FIFO_FLAGS_CHECK_EN
  logic [A:0] ptr_diff;
  logic       mismatch_q, mismatch_d;

  // Natural A+1-bit wrap gives the modulo 2^(A+1) difference.
  assign ptr_diff   = bus.wr_pointer - bus.rd_pointer;
  assign mismatch_d = (ptr_diff != count_q) | (mismatch_q & ~bus.clear_errors);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mismatch_q <= 1'b0;
    end else begin
      mismatch_q <= mismatch_d;
    end
  end

  assign bus.mismatch = mismatch_q;
`else
  logic unused_ptrs;
  assign unused_ptrs  = ^{bus.wr_pointer, bus.rd_pointer};
  assign bus.mismatch = 1'b0;
`endif

  assign bus.wr_increment = wr_inc;
  assign bus.rd_increment = rd_inc;
  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_flags.sv
// tb_fifo_flags: self-checking bench for fifo_flags with A=4, AF_LEVEL=12, AE_LEVEL=2.
// Pointer counters are modelled here as attached hardware and can be preloaded or skewed.
// Expected values come from an integer occupancy model with sticky error bits.
module tb_fifo_flags;
  localparam int unsigned A       = 4;
  localparam int          Depth   = 16;
  localparam int          AfLevel = 12;
  localparam int          AeLevel = 2;
`ifdef FIFO_FLAGS_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       clr = 1'b0;
  logic       ld = 1'b0;
  logic [A:0] ld_wr = '0;
  logic [A:0] ld_rd = '0;
  logic [A:0] wr_ptr, rd_ptr;

  fifo_flags_if #(.A(A)) bus ();

  assign bus.push         = push;
  assign bus.pop          = pop;
  assign bus.clear_errors = clr;
  assign bus.wr_pointer   = wr_ptr;
  assign bus.rd_pointer   = rd_ptr;

  fifo_flags #(.A(A), .AF_LEVEL(AfLevel), .AE_LEVEL(AeLevel)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Attached pointer counters sharing rstn; ld lets the bench preload or skew them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (ld) begin
      wr_ptr <= ld_wr;
      rd_ptr <= ld_rd;
    end else begin
      wr_ptr <= wr_ptr + {4'b0, bus.wr_increment};
      rd_ptr <= rd_ptr + {4'b0, bus.rd_increment};
    end
  end

  int errors = 0;
  int checks = 0;
  int m_cnt  = 0;
  bit m_ovf, m_udf, m_mis;
  bit exp_wi, exp_ri, act_wi, act_ri;

  function automatic bit ptrs_disagree();
    return CheckEn && ((((int'(wr_ptr) - int'(rd_ptr)) + 32) % 32) != m_cnt);
  endfunction

  // One clock: drive at negedge, capture combinational increments, advance model, return at negedge.
  task automatic do_cycle(input bit p, input bit q, input bit c);
    bit mis_now;
    push = p; pop = q; clr = c;
    #1;
    exp_wi  = p && (m_cnt < Depth);
    exp_ri  = q && (m_cnt > 0);
    act_wi  = bus.wr_increment;
    act_ri  = bus.rd_increment;
    mis_now = ptrs_disagree();
    @(posedge clk);
    m_ovf = (p && m_cnt == Depth) ? 1'b1 : (c ? 1'b0 : m_ovf);
    m_udf = (q && m_cnt == 0) ? 1'b1 : (c ? 1'b0 : m_udf);
    m_mis = mis_now ? 1'b1 : (c ? 1'b0 : m_mis);
    m_cnt = m_cnt + int'(exp_wi) - int'(exp_ri);
    @(negedge clk);
    push = 1'b0; pop = 1'b0; clr = 1'b0;
  endtask

  task automatic load_ptrs(input logic [A:0] w, input logic [A:0] r);
    bit mis_now;
    ld_wr = w; ld_rd = r; ld = 1'b1;
    #1;
    mis_now = ptrs_disagree();
    @(posedge clk);
    m_mis = m_mis | mis_now;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic reset_dut();
    rstn = 1'b0; push = 1'b0; pop = 1'b0; clr = 1'b0; ld = 1'b0;
    #12;
    @(negedge clk);
    rstn = 1'b1;
    m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0; m_mis = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    checks++; if (bus.almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae: got %b want 1", bus.almost_empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
    checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL reset_af: got %b want 0", bus.almost_full); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
    checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL reset_udf: got %b want 0", bus.underflow); end
    checks++; if (bus.mismatch !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b want 0", bus.mismatch); end
  endtask

  task automatic test_fill();
    reset_dut();
    for (int i = 1; i <= 16; i++) begin
      do_cycle(1'b1, 1'b0, 1'b0);
      checks++; if (bus.almost_empty !== (i <= AeLevel)) begin errors++; $display("FAIL fill_ae push%0d: got %b want %b", i, bus.almost_empty, (i <= AeLevel)); end
      checks++; if (bus.almost_full !== (i >= AfLevel)) begin errors++; $display("FAIL fill_af push%0d: got %b want %b", i, bus.almost_full, (i >= AfLevel)); end
    end
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL fill_count: got %0d want 16", bus.count); end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", bus.full); end
    checks++; if (wr_ptr !== 5'd16) begin errors++; $display("FAIL fill_wrptr: got %0d want 16", wr_ptr); end
    checks++; if (rd_ptr !== 5'd0) begin errors++; $display("FAIL fill_rdptr: got %0d want 0", rd_ptr); end
    do_cycle(1'b1, 1'b0, 1'b0);
    checks++; if (act_wi !== 1'b0) begin errors++; $display("FAIL ovf_wrinc: got %b want 0", act_wi); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", bus.overflow); end
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d want 16", bus.count); end
    // Push while full together with clear_errors: the set condition wins.
    do_cycle(1'b1, 1'b0, 1'b1);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b want 1", bus.overflow); end
  endtask

  task automatic test_full_push_pop();
    do_cycle(1'b1, 1'b1, 1'b0);
    checks++; if (act_wi !== 1'b0) begin errors++; $display("FAIL fpp_wrinc: got %b want 0", act_wi); end
    checks++; if (act_ri !== 1'b1) begin errors++; $display("FAIL fpp_rdinc: got %b want 1", act_ri); end
    checks++; if (bus.count !== 5'd15) begin errors++; $display("FAIL fpp_count: got %0d want 15", bus.count); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL fpp_full: got %b want 0", bus.full); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL fpp_ovf: got %b want 1", bus.overflow); end
  endtask

  task automatic test_drain_wrap();
    reset_dut();
    load_ptrs(5'd24, 5'd24);
    for (int i = 0; i < 16; i++) do_cycle(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      do_cycle(1'b0, 1'b1, 1'b0);
      checks++; if (rd_ptr !== 5'((24 + i) % 32)) begin errors++; $display("FAIL drain_rdptr pop%0d: got %0d want %0d", i, rd_ptr, (24 + i) % 32); end
    end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL drain_count: got %0d want 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", bus.empty); end
    do_cycle(1'b0, 1'b1, 1'b0);
    checks++; if (act_ri !== 1'b0) begin errors++; $display("FAIL udf_rdinc: got %b want 0", act_ri); end
    checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL udf_flag: got %b want 1", bus.underflow); end
    checks++; if (rd_ptr !== 5'd8) begin errors++; $display("FAIL udf_rdptr: got %0d want 8", rd_ptr); end
    checks++; if (bus.mismatch !== m_mis) begin errors++; $display("FAIL drain_mis: got %b want %b", bus.mismatch, m_mis); end
  endtask

  task automatic test_back_to_back();
    logic [A:0] wp, rp;
    reset_dut();
    do_cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, 1'b0);
    wp = wr_ptr; rp = rd_ptr;
    do_cycle(1'b1, 1'b1, 1'b0);
    checks++; if (bus.count !== 5'd5) begin errors++; $display("FAIL b2b_count: got %0d want 5", bus.count); end
    checks++; if (wr_ptr !== wp + 5'd1) begin errors++; $display("FAIL b2b_wrptr: got %0d want %0d", wr_ptr, wp + 5'd1); end
    checks++; if (rd_ptr !== rp + 5'd1) begin errors++; $display("FAIL b2b_rdptr: got %0d want %0d", rd_ptr, rp + 5'd1); end
    checks++; if ({bus.full, bus.empty, bus.almost_full, bus.almost_empty} !== 4'b0000) begin errors++; $display("FAIL b2b_flags: got %b want 0000", {bus.full, bus.empty, bus.almost_full, bus.almost_empty}); end
    checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL b2b_udf_held: got %b want 1", bus.underflow); end
    do_cycle(1'b0, 1'b0, 1'b1);
    checks++; if ({bus.overflow, bus.underflow, bus.mismatch} !== 3'b000) begin errors++; $display("FAIL clear_errs: got %b want 000", {bus.overflow, bus.underflow, bus.mismatch}); end
  endtask

  task automatic test_mismatch();
    load_ptrs(wr_ptr + 5'd1, rd_ptr);
    do_cycle(1'b0, 1'b0, 1'b0);
    checks++; if (bus.mismatch !== m_mis) begin errors++; $display("FAIL mis_set: got %b want %b", bus.mismatch, m_mis); end
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b0, 1'b0);
    checks++; if (bus.mismatch !== CheckEn) begin errors++; $display("FAIL mis_held: got %b want %b", bus.mismatch, CheckEn); end
    load_ptrs(wr_ptr - 5'd1, rd_ptr);
    do_cycle(1'b0, 1'b0, 1'b1);
    checks++; if (bus.mismatch !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b want 0", bus.mismatch); end
  endtask

  task automatic test_random();
    bit p, q, c;
    int bias;
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      bias = ((i / 40) % 2 == 0) ? 80 : 20;
      p = ($urandom_range(0, 99) < bias);
      q = ($urandom_range(0, 99) < (100 - bias));
      c = ($urandom_range(0, 99) < 5);
      do_cycle(p, q, c);
      checks++; if (act_wi !== exp_wi) begin errors++; $display("FAIL rnd_wrinc cyc%0d: got %b want %b", i, act_wi, exp_wi); end
      checks++; if (act_ri !== exp_ri) begin errors++; $display("FAIL rnd_rdinc cyc%0d: got %b want %b", i, act_ri, exp_ri); end
      checks++; if (bus.count !== 5'(m_cnt)) begin errors++; $display("FAIL rnd_count cyc%0d: got %0d want %0d", i, bus.count, m_cnt); end
      checks++; if (bus.full !== (m_cnt == Depth)) begin errors++; $display("FAIL rnd_full cyc%0d: got %b want %b", i, bus.full, (m_cnt == Depth)); end
      checks++; if (bus.empty !== (m_cnt == 0)) begin errors++; $display("FAIL rnd_empty cyc%0d: got %b want %b", i, bus.empty, (m_cnt == 0)); end
      checks++; if (bus.almost_full !== (m_cnt >= AfLevel)) begin errors++; $display("FAIL rnd_af cyc%0d: got %b want %b", i, bus.almost_full, (m_cnt >= AfLevel)); end
      checks++; if (bus.almost_empty !== (m_cnt <= AeLevel)) begin errors++; $display("FAIL rnd_ae cyc%0d: got %b want %b", i, bus.almost_empty, (m_cnt <= AeLevel)); end
      checks++; if (bus.overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf cyc%0d: got %b want %b", i, bus.overflow, m_ovf); end
      checks++; if (bus.underflow !== m_udf) begin errors++; $display("FAIL rnd_udf cyc%0d: got %b want %b", i, bus.underflow, m_udf); end
      checks++; if (bus.mismatch !== m_mis) begin errors++; $display("FAIL rnd_mis cyc%0d: got %b want %b", i, bus.mismatch, m_mis); end
    end
  endtask

  task automatic test_async_reset();
    reset_dut();
    for (int i = 0; i < 6; i++) do_cycle(1'b1, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) do_cycle(1'b1, 1'b0, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL async_count: got %0d want 0", bus.count); end
    checks++; if ({bus.empty, bus.almost_empty} !== 2'b11) begin errors++; $display("FAIL async_empty: got %b want 11", {bus.empty, bus.almost_empty}); end
    checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL async_udf: got %b want 0", bus.underflow); end
    checks++; if (wr_ptr !== 5'd0) begin errors++; $display("FAIL async_wrptr: got %0d want 0", wr_ptr); end
    reset_dut();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fill();
    test_full_push_pop();
    test_drain_wrap();
    test_back_to_back();
    test_mismatch();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
